ldtu_fast_cmd_ctrl: RTL and testbench

- Sequencer that turns decoded fast commands into the DTU datapath control strobes: flush_b, synch, calibration start and test enable.
- Sits between the fast-command decoder and the LiTE-DTU core, on the same 160 MHz CLK domain.
- Enforces legal ordering of the control strobes:
  - no synch during a flush;
  - an automatic flush after every calibration;
  - reject-and-report of commands that are illegal in the current state.

---
 rtl/ldtu_ctrl_pkg.sv | 35 +++
 rtl/ldtu_ctrl_timer.sv | 35 +++
 rtl/ldtu_fast_cmd_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ldtu_fast_cmd_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ldtu_ctrl_pkg.sv
// Shared definitions for the LiTE-DTU fast-command control sequencer.
// Holds the fast-command codes, the sequencer state encoding and the
// default timing constants used by ldtu_fast_cmd_ctrl and ldtu_ctrl_timer.
package ldtu_ctrl_pkg;

  localparam int unsigned CMD_W = 3;

  // Fast-command codes as delivered by the fast-command decoder
  localparam logic [CMD_W-1:0] CMD_NOP         = 3'd0;
  localparam logic [CMD_W-1:0] CMD_FLUSH       = 3'd1;
  localparam logic [CMD_W-1:0] CMD_SYNCH_START = 3'd2;
  localparam logic [CMD_W-1:0] CMD_SYNCH_STOP  = 3'd3;
  localparam logic [CMD_W-1:0] CMD_CALIB       = 3'd4;
  localparam logic [CMD_W-1:0] CMD_TEST_START  = 3'd5;
  localparam logic [CMD_W-1:0] CMD_TEST_STOP   = 3'd6;
  localparam logic [CMD_W-1:0] CMD_RSVD        = 3'd7;

  // Sequencer states; encoding 3'd7 is unused and recovers to RUN
  typedef enum logic [2:0] {
    RUN      = 3'd0,
    FLUSH    = 3'd1,
    SYNCH    = 3'd2,
    CAL_REQ  = 3'd3,
    CAL_ACK  = 3'd4,
    CAL_WAIT = 3'd5,
    TEST     = 3'd6
  } state_e;

  // Default timing constants
  localparam int unsigned DEF_CNT_W         = 16;
  localparam int unsigned DEF_FLUSH_LEN     = 4;
  localparam int unsigned DEF_SYNCH_TIMEOUT = 1024;
  localparam int unsigned DEF_CAL_ACK_LEN   = 64;

endpackage

// File: rtl/ldtu_ctrl_timer.sv
// Loadable down-counter with a zero flag, shared by the FLUSH, SYNCH and
// CAL_ACK states of the fast-command sequencer.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   load        - load load_val this cycle (takes priority over counting)
//   load_val    - value loaded into the counter
//   zero_c      - combinational flag: counter currently equals zero
module ldtu_ctrl_timer
  import ldtu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] count;

  // Counts down and parks at zero until the next load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/ldtu_fast_cmd_ctrl.sv
// Fast-command sequencer: turns decoded fast commands into the LiTE-DTU
// datapath control strobes and enforces their legal ordering (no synch
// during a flush, automatic flush after calibration and after test mode,
// reject-and-report of commands that are illegal in the current state).
// Ports:
//   CLK, rst_b   - 160 MHz clock, asynchronous active-low reset
//   cmd_valid    - one-cycle strobe qualifying cmd_code
//   cmd_code     - fast-command code (see ldtu_ctrl_pkg)
//   calib_busy   - OR of the ADC calibration-busy flags, synchronous to CLK
//   flush_b      - active-low flush to encoder/CU/oFIFO
//   synch        - synch mode to oFIFO
//   calib_start  - one-cycle calibration request to the ADCs
//   test_enable  - ATU test-mode select
//   busy         - high whenever the sequencer is not in RUN
//   cmd_reject   - one-cycle pulse for an illegal or reserved command
//   timeout      - one-cycle pulse for synch or calibration-ack timeout
module ldtu_fast_cmd_ctrl
  import ldtu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned FLUSH_LEN     = DEF_FLUSH_LEN,
  parameter int unsigned SYNCH_TIMEOUT = DEF_SYNCH_TIMEOUT,
  parameter int unsigned CAL_ACK_LEN   = DEF_CAL_ACK_LEN
) (
  input  logic             CLK,
  input  logic             rst_b,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd_code,
  input  logic             calib_busy,
  output logic             flush_b,
  output logic             synch,
  output logic             calib_start,
  output logic             test_enable,
  output logic             busy,
  output logic             cmd_reject,
  output logic             timeout
);

  state_e           state_q;
  state_e           state_d;
  logic             reject_d;
  logic             timeout_d;
  logic             any_cmd;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_zero;

  // Any real (non-NOP) command this cycle
  assign any_cmd = cmd_valid && (cmd_code != CMD_NOP);

  // Next-state and pulse decode
  always_comb begin
    state_d   = state_q;
    reject_d  = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      RUN: begin
        if (cmd_valid) begin
          case (cmd_code)
            CMD_FLUSH:       state_d  = FLUSH;
            CMD_SYNCH_START: state_d  = SYNCH;
            CMD_CALIB:       state_d  = CAL_REQ;
            CMD_TEST_START:  state_d  = TEST;
            CMD_SYNCH_STOP,
            CMD_TEST_STOP,
            CMD_RSVD:        reject_d = 1'b1;
            default:         ;
          endcase
        end
      end
      FLUSH: begin
        reject_d = any_cmd;
        if (tmr_zero) state_d = RUN;
      end
      SYNCH: begin
        // A stop coinciding with expiry wins and suppresses the timeout
        if (cmd_valid && (cmd_code == CMD_SYNCH_STOP)) begin
          state_d = RUN;
        end else begin
          reject_d = any_cmd;
          if (tmr_zero) begin
            state_d   = RUN;
            timeout_d = 1'b1;
          end
        end
      end
      CAL_REQ: begin
        reject_d = any_cmd;
        state_d  = CAL_ACK;
      end
      CAL_ACK: begin
        // ADC acknowledgement takes priority over an expiring counter
        reject_d = any_cmd;
        if (calib_busy) begin
          state_d = CAL_WAIT;
        end else if (tmr_zero) begin
          state_d   = RUN;
          timeout_d = 1'b1;
        end
      end
      CAL_WAIT: begin
        reject_d = any_cmd;
        if (!calib_busy) state_d = FLUSH;
      end
      TEST: begin
        if (cmd_valid && (cmd_code == CMD_TEST_STOP)) begin
          state_d = FLUSH;
        end else begin
          reject_d = any_cmd;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Counter reloads on every state change with the entered state's budget
  assign tmr_load = (state_d != state_q);

  always_comb begin
    tmr_load_val = '0;
    case (state_d)
      FLUSH:   tmr_load_val = CNT_W'(FLUSH_LEN - 1);
      SYNCH:   tmr_load_val = CNT_W'(SYNCH_TIMEOUT - 1);
      CAL_ACK: tmr_load_val = CNT_W'(CAL_ACK_LEN - 1);
      default: tmr_load_val = '0;
    endcase
  end

  ldtu_ctrl_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (CLK),
    .rst_n    (rst_b),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .zero_c   (tmr_zero)
  );

  // State register and registered strobes, decoded from the next state
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= RUN;
      flush_b     <= 1'b1;
      synch       <= 1'b0;
      calib_start <= 1'b0;
      test_enable <= 1'b0;
      busy        <= 1'b0;
      cmd_reject  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_b     <= (state_d != FLUSH);
      synch       <= (state_d == SYNCH);
      calib_start <= (state_d == CAL_REQ);
      test_enable <= (state_d == TEST);
      busy        <= (state_d != RUN);
      cmd_reject  <= reject_d;
      timeout     <= timeout_d;
    end
  end

endmodule

// File: tb/tb_ldtu_fast_cmd_ctrl.sv
// Directed self-checking bench for ldtu_fast_cmd_ctrl.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ldtu_fast_cmd_ctrl;
  import ldtu_ctrl_pkg::*;

  logic       CLK;
  logic       rst_b;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       calib_busy;
  logic       flush_b;
  logic       synch;
  logic       calib_start;
  logic       test_enable;
  logic       busy;
  logic       cmd_reject;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  // Output vector: {flush_b, synch, calib_start, test_enable, busy, cmd_reject, timeout}
  localparam logic [6:0] O_IDLE  = 7'b1000000;
  localparam logic [6:0] O_FLUSH = 7'b0000100;
  localparam logic [6:0] O_SYNCH = 7'b1100100;
  localparam logic [6:0] O_CREQ  = 7'b1010100;
  localparam logic [6:0] O_CAL   = 7'b1000100;
  localparam logic [6:0] O_TEST  = 7'b1001100;
  localparam logic [6:0] REJ     = 7'b0000010;
  localparam logic [6:0] TMO     = 7'b0000001;

  ldtu_fast_cmd_ctrl #(
    .CNT_W         (16),
    .FLUSH_LEN     (4),
    .SYNCH_TIMEOUT (32),
    .CAL_ACK_LEN   (64)
  ) dut (
    .CLK         (CLK),
    .rst_b       (rst_b),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .calib_busy  (calib_busy),
    .flush_b     (flush_b),
    .synch       (synch),
    .calib_start (calib_start),
    .test_enable (test_enable),
    .busy        (busy),
    .cmd_reject  (cmd_reject),
    .timeout     (timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [6:0] outs();
    return {flush_b, synch, calib_start, test_enable, busy, cmd_reject, timeout};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Present one command for a cycle; returns on the following falling edge
  task automatic tick(input logic v, input logic [2:0] c);
    cmd_valid = v;
    cmd_code  = c;
    @(negedge CLK);
    cmd_valid = 1'b0;
    cmd_code  = CMD_NOP;
  endtask

  // Expect exp for n consecutive idle cycles
  task automatic hold(input string tag, input int n, input logic [6:0] exp);
    for (int i = 0; i < n; i++) begin
      check(tag, 32'(outs()), 32'(exp));
      tick(1'b0, CMD_NOP);
    end
  endtask

  initial begin
    int synch_cycles;
    rst_b      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_code   = CMD_NOP;
    calib_busy = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_outs", 32'(outs()), 32'(O_IDLE));
    rst_b = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_outs", 32'(outs()), 32'(O_IDLE));

    // Flush with a synch request arriving in flush cycle 2
    tick(1'b1, CMD_FLUSH);
    check("flush_c1", 32'(outs()), 32'(O_FLUSH));
    tick(1'b0, CMD_NOP);
    check("flush_c2", 32'(outs()), 32'(O_FLUSH));
    tick(1'b1, CMD_SYNCH_START);
    check("flush_c3_rej", 32'(outs()), 32'(O_FLUSH | REJ));
    tick(1'b0, CMD_NOP);
    check("flush_c4", 32'(outs()), 32'(O_FLUSH));
    tick(1'b0, CMD_NOP);
    check("flush_done", 32'(outs()), 32'(O_IDLE));

    // cmd_valid low ignores cmd_code
    tick(1'b0, CMD_FLUSH);
    check("novalid", 32'(outs()), 32'(O_IDLE));

    // Illegal commands in RUN
    tick(1'b1, CMD_RSVD);
    check("run_rsvd_rej", 32'(outs()), 32'(O_IDLE | REJ));
    tick(1'b1, CMD_SYNCH_STOP);
    check("run_sstop_rej", 32'(outs()), 32'(O_IDLE | REJ));
    tick(1'b1, CMD_TEST_STOP);
    check("run_tstop_rej", 32'(outs()), 32'(O_IDLE | REJ));
    tick(1'b1, CMD_NOP);
    check("run_nop", 32'(outs()), 32'(O_IDLE));

    // Synch started then stopped 20 cycles later
    synch_cycles = 0;
    tick(1'b1, CMD_SYNCH_START);
    for (int i = 0; i < 20; i++) begin
      check("synch_on", 32'(outs()), 32'(O_SYNCH));
      if (synch) synch_cycles++;
      tick(i == 19, (i == 19) ? CMD_SYNCH_STOP : CMD_NOP);
    end
    check("synch_len20", 32'(synch_cycles), 32'd20);
    check("synch_stop", 32'(outs()), 32'(O_IDLE));
    tick(1'b0, CMD_NOP);
    check("synch_no_tmo", 32'(outs()), 32'(O_IDLE));

    // Synch left running until timeout, with a rejected command inside
    tick(1'b1, CMD_SYNCH_START);
    for (int i = 0; i < 32; i++) begin
      check("synch_to_on", 32'(outs()), 32'((i == 6) ? (O_SYNCH | REJ) : O_SYNCH));
      tick(i == 5, (i == 5) ? CMD_FLUSH : CMD_NOP);
    end
    check("synch_timeout", 32'(outs()), 32'(O_IDLE | TMO));
    tick(1'b0, CMD_NOP);
    check("synch_to_after", 32'(outs()), 32'(O_IDLE));

    // Stop arriving in the same cycle the counter expires
    tick(1'b1, CMD_SYNCH_START);
    for (int i = 0; i < 32; i++) begin
      check("synch_edge_on", 32'(outs()), 32'(O_SYNCH));
      tick(i == 31, (i == 31) ? CMD_SYNCH_STOP : CMD_NOP);
    end
    check("synch_stop_wins", 32'(outs()), 32'(O_IDLE));

    // Calibration: busy rises 5 cycles after calib_start, falls 100 later
    tick(1'b1, CMD_CALIB);
    check("cal_start", 32'(outs()), 32'(O_CREQ));
    tick(1'b0, CMD_NOP);
    hold("cal_ack", 4, O_CAL);
    calib_busy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      check("cal_wait", 32'(outs()), 32'((i == 51) ? (O_CAL | REJ) : O_CAL));
      tick(i == 50, (i == 50) ? CMD_TEST_START : CMD_NOP);
    end
    calib_busy = 1'b0;
    check("cal_busy_fall", 32'(outs()), 32'(O_CAL));
    tick(1'b0, CMD_NOP);
    hold("cal_flush", 4, O_FLUSH);
    check("cal_done", 32'(outs()), 32'(O_IDLE));

    // Calibration never acknowledged
    tick(1'b1, CMD_CALIB);
    check("cal_to_start", 32'(outs()), 32'(O_CREQ));
    tick(1'b0, CMD_NOP);
    hold("cal_to_ack", 64, O_CAL);
    check("cal_timeout", 32'(outs()), 32'(O_IDLE | TMO));
    tick(1'b0, CMD_NOP);
    check("cal_to_noflush", 32'(outs()), 32'(O_IDLE));

    // Test mode with a reserved command, then stop and flush
    tick(1'b1, CMD_TEST_START);
    check("test_on", 32'(outs()), 32'(O_TEST));
    tick(1'b1, CMD_RSVD);
    check("test_rsvd_rej", 32'(outs()), 32'(O_TEST | REJ));
    tick(1'b0, CMD_NOP);
    check("test_hold", 32'(outs()), 32'(O_TEST));
    tick(1'b1, CMD_TEST_STOP);
    hold("test_flush", 4, O_FLUSH);
    check("test_done", 32'(outs()), 32'(O_IDLE));

    // Asynchronous reset during flush cycle 2
    tick(1'b1, CMD_FLUSH);
    check("rst_flush_c1", 32'(outs()), 32'(O_FLUSH));
    tick(1'b0, CMD_NOP);
    check("rst_flush_c2", 32'(outs()), 32'(O_FLUSH));
    #1 rst_b = 1'b0;
    #1 check("rst_async", 32'(outs()), 32'(O_IDLE));
    @(negedge CLK);
    rst_b = 1'b1;
    tick(1'b0, CMD_NOP);
    check("rst_no_resume", 32'(outs()), 32'(O_IDLE));
    tick(1'b1, CMD_FLUSH);
    hold("rst_reflush", 4, O_FLUSH);
    check("rst_reflush_done", 32'(outs()), 32'(O_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
